// File: rtl/fft_frame_sequencer_if.sv
// Bundle of UART-side, RAM-side and FFT-core-side signals for fft_frame_sequencer.
// master = the sequencer, slave = its surroundings (UART, RAM, FFT core).
interface fft_frame_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic [1:0]          fft_select_i;
    logic                frame_start_i;
    logic                sample_valid_i;
    logic [DATA_W-1:0]   sample_R_i;
    logic [DATA_W-1:0]   sample_I_i;
    logic                frame_end_i;
    logic                mem_we_o;
    logic [ADDR_W-1:0]   mem_waddr_o;
    logic [2*DATA_W-1:0] mem_wdata_o;
    logic                mem_re_o;
    logic [ADDR_W-1:0]   mem_raddr_o;
    logic [2*DATA_W-1:0] mem_rdata_i;
    logic                fft_start_o;
    logic                fft_done_i;
    logic [DATA_W-1:0]   coeff_R_o;
    logic [DATA_W-1:0]   coeff_I_o;
    logic                coeff_valid_o;
    logic                coeff_ready_i;
    logic                tx_start_o;
    logic                busy_o;
    logic                error_o;

    modport master (
        input  fft_select_i, frame_start_i, sample_valid_i, sample_R_i, sample_I_i,
               frame_end_i, mem_rdata_i, fft_done_i, coeff_ready_i,
        output mem_we_o, mem_waddr_o, mem_wdata_o, mem_re_o, mem_raddr_o,
               fft_start_o, coeff_R_o, coeff_I_o, coeff_valid_o, tx_start_o,
               busy_o, error_o
    );

    modport slave (
        output fft_select_i, frame_start_i, sample_valid_i, sample_R_i, sample_I_i,
               frame_end_i, mem_rdata_i, fft_done_i, coeff_ready_i,
        input  mem_we_o, mem_waddr_o, mem_wdata_o, mem_re_o, mem_raddr_o,
               fft_start_o, coeff_R_o, coeff_I_o, coeff_valid_o, tx_start_o,
               busy_o, error_o
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer: UART samples -> RAM -> FFT core run -> coefficient readout to UART TX.
// Define FFT_SEQ_BITREV_EN to store samples at bit-reversed addresses (readout stays natural).
module fft_frame_sequencer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 5,
    parameter int FFT_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_frame_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(FFT_TIMEOUT);
    localparam logic [ADDR_W:0]  IDX_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]  N8       = (ADDR_W+1)'(8);
    localparam logic [ADDR_W:0]  N16      = (ADDR_W+1)'(16);
    localparam logic [ADDR_W:0]  N32      = (ADDR_W+1)'(32);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(FFT_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_LATCH, S_SEND, S_DONE, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] coeff_r_q, coeff_r_d;
    logic [DATA_W-1:0] coeff_i_q, coeff_i_d;

    logic [ADDR_W:0]   idx_inc;
    logic [ADDR_W:0]   n_decode;
    logic              load_ok;
    logic              overrun;
    logic [ADDR_W-1:0] wr_addr;

    assign idx_inc = idx_q + IDX_ONE;
    assign load_ok = (idx_q < n_q);

    always_comb begin
        case (bus.fft_select_i)
            2'b00:   n_decode = N8;
            2'b01:   n_decode = N16;
            default: n_decode = N32;
        endcase
    end

`ifdef FFT_SEQ_BITREV_EN
    // Reverse all ADDR_W bits, then shift down so only the low log2N bits remain reversed.
    logic [ADDR_W-1:0] idx_rev;
    int                shamt;
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_rev
        assign idx_rev[gi] = idx_q[ADDR_W-1-gi];
    end
    always_comb begin
        if (n_q == N8)       shamt = ADDR_W - 3;
        else if (n_q == N16) shamt = ADDR_W - 4;
        else                 shamt = ADDR_W - 5;
        wr_addr = idx_rev >> shamt;
    end
`else
    assign wr_addr = idx_q[ADDR_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            coeff_r_q <= '0;
            coeff_i_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            coeff_r_q <= coeff_r_d;
            coeff_i_q <= coeff_i_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        coeff_r_d = coeff_r_q;
        coeff_i_d = coeff_i_q;
        overrun   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.frame_start_i) begin
                    if (bus.fft_select_i == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        n_d     = n_decode;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (bus.frame_start_i) begin
                    if (bus.fft_select_i == 2'b11) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        n_d   = n_decode;
                        idx_d = '0;
                        err_d = 1'b0;
                    end
                end else begin
                    overrun = bus.sample_valid_i && !load_ok;
                    if (bus.sample_valid_i && load_ok) idx_d = idx_inc;
                    // frame_end is judged against the count including a same-cycle sample
                    if (overrun) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else if (bus.frame_end_i) begin
                        if (idx_d == n_q) begin
                            state_d = S_START;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_ERROR;
                        end
                    end
                end
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.fft_done_i) begin
                    idx_d   = '0;
                    state_d = S_READ;
                end else begin
                    tmo_d = tmo_q + CNT_ONE;
                    if (tmo_d == TMO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end
                end
            end
            S_READ:  state_d = S_LATCH;
            S_LATCH: begin
                coeff_r_d = bus.mem_rdata_i[2*DATA_W-1:DATA_W];
                coeff_i_d = bus.mem_rdata_i[DATA_W-1:0];
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (bus.coeff_ready_i) begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc == n_q) ? S_DONE : S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_we_o      = (state_q == S_LOAD) && bus.sample_valid_i && !bus.frame_start_i && load_ok;
        bus.mem_waddr_o   = bus.mem_we_o ? wr_addr : '0;
        bus.mem_wdata_o   = bus.mem_we_o ? {bus.sample_R_i, bus.sample_I_i} : '0;
        bus.mem_re_o      = (state_q == S_READ);
        bus.mem_raddr_o   = bus.mem_re_o ? idx_q[ADDR_W-1:0] : '0;
        bus.fft_start_o   = (state_q == S_START);
        bus.coeff_valid_o = (state_q == S_SEND);
        bus.tx_start_o    = (state_q == S_READ) || (state_q == S_LATCH) ||
                            (state_q == S_SEND) || (state_q == S_DONE);
        bus.busy_o        = (state_q != S_IDLE);
        bus.error_o       = err_q;
        bus.coeff_R_o     = coeff_r_q;
        bus.coeff_I_o     = coeff_i_q;
    end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: frame table plus scoreboarded RAM writes, reads and coefficients.
module tb_fft_frame_sequencer;
    localparam int DW  = 16;
    localparam int AW  = 5;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_frame_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();
    fft_frame_sequencer #(.DATA_W(DW), .ADDR_W(AW), .FFT_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif)
    );

    typedef struct { logic [AW-1:0] addr; logic [2*DW-1:0] data; } wr_t;
    typedef struct {
        logic [1:0] sel; int nsamp; bit end_same; bit send_end;
        bit exp_start; bit exp_err; int stall_idx; bit rst_in_send;
    } vec_t;

    wr_t              wq[$];
    logic [2*DW-1:0]  cq[$];
    logic [2*DW-1:0]  coeff_mem [32];
    int n_checks = 0;
    int n_pass   = 0;
    int n_starts = 0;
    int exp_raddr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [AW-1:0] tb_addr(input int i, input int n);
        logic [AW-1:0] r;
        r = AW'(i);
`ifdef FFT_SEQ_BITREV_EN
        begin
            int lg;
            lg = (n == 8) ? 3 : (n == 16) ? 4 : 5;
            r = '0;
            for (int b = 0; b < lg; b++) r[lg-1-b] = i[b];
        end
`else
        if (n < 0) r = '0;
`endif
        return r;
    endfunction

    // RAM model with one-cycle registered read
    always @(posedge clk) if (bif.mem_re_o) bif.mem_rdata_i <= coeff_mem[bif.mem_raddr_o];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bif.mem_we_o) begin
                check("write_expected", 64'(wq.size() != 0), 64'(1));
                if (wq.size() != 0) begin
                    wr_t e;
                    e = wq.pop_front();
                    check("waddr", 64'(bif.mem_waddr_o), 64'(e.addr));
                    check("wdata", 64'(bif.mem_wdata_o), 64'(e.data));
                    $display("write addr=%0d data=%08h", bif.mem_waddr_o, bif.mem_wdata_o);
                end
            end
            if (bif.fft_start_o) n_starts++;
            if (bif.mem_re_o) begin
                check("raddr", 64'(bif.mem_raddr_o), 64'(exp_raddr));
                exp_raddr++;
            end
            if (bif.coeff_valid_o && bif.coeff_ready_i) begin
                check("coeff_expected", 64'(cq.size() != 0), 64'(1));
                if (cq.size() != 0) begin
                    logic [2*DW-1:0] c;
                    c = cq.pop_front();
                    check("coeff", 64'({bif.coeff_R_o, bif.coeff_I_o}), 64'(c));
                    $display("coeff R=%04h I=%04h", bif.coeff_R_o, bif.coeff_I_o);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({bif.mem_we_o, bif.mem_re_o, bif.fft_start_o, bif.coeff_valid_o,
                                   bif.tx_start_o, bif.busy_o, bif.error_o, bif.mem_waddr_o,
                                   bif.mem_raddr_o}), 64'(0));
        check({tag, "_wdata"}, 64'(bif.mem_wdata_o), 64'(0));
        check({tag, "_coeff"}, 64'({bif.coeff_R_o, bif.coeff_I_o}), 64'(0));
    endtask

    task automatic load_frame(input logic [1:0] sel, input int nsamp, input bit end_same,
                              input bit send_end, input int vi);
        int n;
        n = (sel == 2'b00) ? 8 : (sel == 2'b01) ? 16 : 32;
        bif.fft_select_i = sel;
        bif.frame_start_i = 1'b1;
        cyc();
        bif.frame_start_i = 1'b0;
        check("busy_after_start", 64'(bif.busy_o), 64'(1));
        check("error_cleared", 64'(bif.error_o), 64'(0));
        for (int i = 0; i < nsamp; i++) begin
            bif.sample_valid_i = 1'b1;
            bif.sample_R_i = DW'(i << 8) | DW'(vi);
            bif.sample_I_i = (vi == 0) ? '0 : DW'($urandom);
            if (i < n) wq.push_back('{tb_addr(i, n), {bif.sample_R_i, bif.sample_I_i}});
            bif.frame_end_i = end_same && (i == nsamp - 1);
            cyc();
            bif.sample_valid_i = 1'b0;
            bif.frame_end_i = 1'b0;
        end
        if (send_end && !end_same) begin
            bif.frame_end_i = 1'b1;
            cyc();
            bif.frame_end_i = 1'b0;
        end
        check("writes_consumed", 64'(wq.size()), 64'(0));
    endtask

    task automatic wait_start();
        int t = 0;
        while (!bif.fft_start_o && t < 8) begin cyc(); t++; end
        check("fft_start_seen", 64'(bif.fft_start_o), 64'(1));
    endtask

    task automatic run_frame(input vec_t v, input int vi);
        int n, s0, t;
        logic [2*DW-1:0] held;
        n = (v.sel == 2'b00) ? 8 : (v.sel == 2'b01) ? 16 : 32;
        s0 = n_starts;
        load_frame(v.sel, v.nsamp, v.end_same, v.send_end, vi);
        if (v.exp_start) begin
            wait_start();
            repeat (4) cyc();
            check("one_start_pulse", 64'(n_starts - s0), 64'(1));
            for (int k = 0; k < n; k++) begin
                coeff_mem[k] = $urandom;
                cq.push_back(coeff_mem[k]);
            end
            exp_raddr = 0;
            bif.fft_done_i = 1'b1;
            cyc();
            bif.fft_done_i = 1'b0;
            for (int k = 0; k < n; k++) begin
                t = 0;
                while (!bif.coeff_valid_o && t < 10) begin cyc(); t++; end
                check("coeff_valid", 64'(bif.coeff_valid_o), 64'(1));
                check("tx_active", 64'(bif.tx_start_o), 64'(1));
                if (k > 0) check("cadence", 64'(t), 64'(2));
                if (v.rst_in_send) begin
                    #2 rst_n = 1'b0;
                    #1 check_all_zero("reset_in_send");
                    cq.delete();
                    cyc();
                    rst_n = 1'b1;
                    $display("frame %0d: reset during SEND", vi);
                    return;
                end
                if (k == v.stall_idx) begin
                    held = {bif.coeff_R_o, bif.coeff_I_o};
                    repeat (10) begin
                        cyc();
                        check("stall_hold", 64'({bif.coeff_R_o, bif.coeff_I_o, bif.coeff_valid_o}),
                              64'({held, 1'b1}));
                    end
                end
                bif.coeff_ready_i = 1'b1;
                cyc();
                bif.coeff_ready_i = 1'b0;
            end
            check("done_tx", 64'({bif.tx_start_o, bif.busy_o}), 64'(2'b11));
            cyc();
            check("idle_after_done", 64'({bif.tx_start_o, bif.busy_o}), 64'(0));
            check("coeffs_consumed", 64'(cq.size()), 64'(0));
        end else begin
            repeat (2) cyc();
            check("busy_idle", 64'(bif.busy_o), 64'(0));
            check("no_start", 64'(n_starts - s0), 64'(0));
        end
        check("error_final", 64'(bif.error_o), 64'(v.exp_err));
        $display("frame %0d: sel=%0d samples=%0d error=%0b", vi, v.sel, v.nsamp, bif.error_o);
    endtask

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        vecs[0] = '{2'b00,  8, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0};
        vecs[1] = '{2'b10, 32, 1'b0, 1'b1, 1'b1, 1'b0,  2, 1'b0};
        vecs[2] = '{2'b01, 15, 1'b0, 1'b1, 1'b0, 1'b1, -1, 1'b0};
        vecs[3] = '{2'b00,  8, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0};
        vecs[4] = '{2'b00,  9, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0};
        vecs[5] = '{2'b01, 16, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0};
        vecs[6] = '{2'b00,  8, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b1};
        vecs[7] = '{2'b00,  8, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0};

        bif.fft_select_i = 2'b00;
        bif.frame_start_i = 1'b0;
        bif.sample_valid_i = 1'b0;
        bif.sample_R_i = '0;
        bif.sample_I_i = '0;
        bif.frame_end_i = 1'b0;
        bif.fft_done_i = 1'b0;
        bif.coeff_ready_i = 1'b0;
        for (int k = 0; k < 32; k++) coeff_mem[k] = '0;

        repeat (3) cyc();
        check_all_zero("reset");
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 8; i++) run_frame(vecs[i], i);

        // Reserved select: error without leaving IDLE
        bif.fft_select_i = 2'b11;
        bif.frame_start_i = 1'b1;
        cyc();
        bif.frame_start_i = 1'b0;
        check("sel11_error", 64'(bif.error_o), 64'(1));
        check("sel11_busy", 64'(bif.busy_o), 64'(0));
        cyc();
        check("sel11_busy_stays", 64'(bif.busy_o), 64'(0));
        $display("select=11: error=%0b busy=%0b", bif.error_o, bif.busy_o);

        // FFT core never answers: error 16 cycles after the start pulse
        load_frame(2'b00, 8, 1'b0, 1'b1, 9);
        wait_start();
        c = 0;
        while (!bif.error_o && c < 40) begin cyc(); c++; end
        check("timeout_cycles", 64'(c), 64'(TMO));
        cyc();
        check("timeout_idle", 64'({bif.busy_o, bif.error_o}), 64'(2'b01));
        $display("timeout: error after %0d cycles", c);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
